// File: rtl/serdes_shift_engine_pkg.sv
// Shared types and helpers for the serdes shift engine.
// Optional even-parity framing is enabled by defining SERDES_PARITY_EN.
package serdes_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_e;

`ifdef SERDES_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // A zero length, or one wider than the datapath, selects a full-width frame.
    function automatic int eff_len(input int frame_len, input int data_w);
        if (frame_len == 0 || frame_len > data_w) return data_w;
        return frame_len;
    endfunction

endpackage

// File: rtl/serdes_shift_engine_if.sv
// Bundle of the parallel handshakes, frame controls and serial lines of the serdes shift engine.
interface serdes_shift_engine_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W + 1)
);
    // valid/ready: a word moves on every cycle where both are 1; the source holds its
    // data stable while valid=1 and ready=0, and valid never waits on ready.
    logic              bit_tick;
    logic              msb_first;
    logic [CNT_W-1:0]  frame_len;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              tx_serial;
    logic              tx_done;
    logic              rx_enable;
    logic              rx_serial;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              rx_overrun;
    logic              rx_parity_err;

    modport master (
        output bit_tick, msb_first, frame_len, tx_valid, tx_data, rx_enable, rx_serial, rx_ready,
        input  tx_ready, tx_serial, tx_done, rx_data, rx_valid, rx_overrun, rx_parity_err
    );

    modport slave (
        input  bit_tick, msb_first, frame_len, tx_valid, tx_data, rx_enable, rx_serial, rx_ready,
        output tx_ready, tx_serial, tx_done, rx_data, rx_valid, rx_overrun, rx_parity_err
    );

endinterface

// File: rtl/serdes_bit_counter.sv
// Loadable down-counter with clear and terminal-count (zero) flag; tracks bits left in a frame.
module serdes_bit_counter #(
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          tc
);

    logic [CW-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (dec && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == '0);

endmodule

// File: rtl/serdes_shift_engine.sv
// Full-duplex parametrised serialiser/deserialiser with per-frame length and bit order.
// Defining SERDES_PARITY_EN appends an even-parity bit to every frame in both directions.
module serdes_shift_engine
    import serdes_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input logic                  clk,
    input logic                  reset,
    serdes_shift_engine_if.slave bus
);

    // One spare counter bit so that a full-width frame plus parity always fits.
    localparam int CW = CNT_W + 1;
    localparam logic [CW-1:0] PAR_CW = CW'(PARITY_BITS);

    logic [CW-1:0]     in_len;
    logic [DATA_W-1:0] in_mask;

    assign in_len  = CW'(eff_len(int'(bus.frame_len), DATA_W));
    assign in_mask = {DATA_W{1'b1}} >> (DATA_W - int'(in_len));

    tx_state_e         tx_state_d, tx_state_q;
    logic [DATA_W-1:0] tx_sh_d, tx_sh_q;
    logic              tx_msb_d, tx_msb_q;
    logic              tx_serial_d, tx_serial_q;
    logic              tx_par_d, tx_par_q;
    logic              tx_load, tx_dec, tx_tc, tx_done_c;
    logic [CW-1:0]     tx_cnt;

    serdes_bit_counter #(.CW(CW)) u_tx_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .load     (tx_load),
        .load_val (in_len + PAR_CW),
        .dec      (tx_dec),
        .count    (tx_cnt),
        .tc       (tx_tc)
    );

    // MSB-first words are left-aligned at load so both orders shift out from a fixed end.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_sh_d     = tx_sh_q;
        tx_msb_d    = tx_msb_q;
        tx_serial_d = tx_serial_q;
        tx_par_d    = tx_par_q;
        tx_load     = 1'b0;
        tx_dec      = 1'b0;
        tx_done_c   = 1'b0;
        case (tx_state_q)
            IDLE: begin
                tx_serial_d = 1'b1;
                if (bus.tx_valid) begin
                    tx_state_d = SHIFT;
                    tx_load    = 1'b1;
                    tx_msb_d   = bus.msb_first;
                    tx_sh_d    = bus.msb_first ? (bus.tx_data << (DATA_W - int'(in_len))) : bus.tx_data;
                    tx_par_d   = ^(bus.tx_data & in_mask);
                end
            end
            SHIFT: begin
                if (bus.bit_tick) begin
                    if (tx_tc) begin
                        tx_serial_d = 1'b1;
                        tx_done_c   = 1'b1;
                        tx_state_d  = IDLE;
                    end else begin
                        tx_dec = 1'b1;
                        if (PARITY_BITS != 0 && tx_cnt == CW'(1)) begin
                            tx_serial_d = tx_par_q;
                        end else if (tx_msb_q) begin
                            tx_serial_d = tx_sh_q[DATA_W-1];
                            tx_sh_d     = tx_sh_q << 1;
                        end else begin
                            tx_serial_d = tx_sh_q[0];
                            tx_sh_d     = tx_sh_q >> 1;
                        end
                    end
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q  <= IDLE;
            tx_sh_q     <= '0;
            tx_msb_q    <= 1'b0;
            tx_serial_q <= 1'b1;
            tx_par_q    <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_sh_q     <= tx_sh_d;
            tx_msb_q    <= tx_msb_d;
            tx_serial_q <= tx_serial_d;
            tx_par_q    <= tx_par_d;
        end
    end

    assign bus.tx_ready  = (tx_state_q == IDLE);
    assign bus.tx_serial = tx_serial_q;
    assign bus.tx_done   = tx_done_c;

    logic [DATA_W-1:0] rx_sh_d, rx_sh_q, rx_data_d, rx_data_q;
    logic [DATA_W-1:0] rx_base, rx_shifted, rx_word_src, rx_word;
    logic [CW-1:0]     rx_len_d, rx_len_q, rx_cur_len, rx_cnt;
    logic              rx_msb_d, rx_msb_q, rx_cur_msb;
    logic              rx_sample, rx_first, rx_par_bit, rx_complete;
    logic              rx_load, rx_dec, rx_tc;
    logic              rx_valid_d, rx_valid_q, rx_ovr_d, rx_ovr_q;

    // Counter holds bits still expected; zero means the next sample starts a frame.
    serdes_bit_counter #(.CW(CW)) u_rx_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (!bus.rx_enable),
        .load     (rx_load),
        .load_val (in_len + PAR_CW - CW'(1)),
        .dec      (rx_dec),
        .count    (rx_cnt),
        .tc       (rx_tc)
    );

    always_comb begin
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        rx_len_d    = rx_len_q;
        rx_msb_d    = rx_msb_q;
        rx_valid_d  = rx_valid_q;
        rx_ovr_d    = 1'b0;
        rx_load     = 1'b0;
        rx_dec      = 1'b0;
        rx_sample   = bus.rx_enable && bus.bit_tick;
        rx_first    = rx_tc;
        rx_cur_len  = rx_first ? in_len : rx_len_q;
        rx_cur_msb  = rx_first ? bus.msb_first : rx_msb_q;
        rx_base     = rx_first ? '0 : rx_sh_q;
        rx_par_bit  = (PARITY_BITS != 0) && !rx_first && (rx_cnt == CW'(1));
        rx_complete = rx_sample && (rx_first ? ((in_len + PAR_CW) == CW'(1)) : (rx_cnt == CW'(1)));
        rx_shifted  = rx_cur_msb ? {rx_base[DATA_W-2:0], bus.rx_serial}
                                 : {bus.rx_serial, rx_base[DATA_W-1:1]};
        rx_word_src = rx_par_bit ? rx_sh_q : rx_shifted;
        // LSB-first bits enter at the top, so right-align by the frame length.
        rx_word     = rx_cur_msb ? rx_word_src : (rx_word_src >> (DATA_W - int'(rx_cur_len)));
        if (rx_sample) begin
            rx_len_d = rx_cur_len;
            rx_msb_d = rx_cur_msb;
            rx_load  = rx_first;
            rx_dec   = !rx_first;
            if (!rx_par_bit) begin
                rx_sh_d = rx_shifted;
            end
        end
        if (bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (rx_complete) begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            rx_ovr_d   = rx_valid_q && !bus.rx_ready;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_len_q   <= '0;
            rx_msb_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_len_q   <= rx_len_d;
            rx_msb_q   <= rx_msb_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.rx_overrun = rx_ovr_q;

`ifdef SERDES_PARITY_EN
    logic rx_acc_d, rx_acc_q, rx_perr_d, rx_perr_q;

    always_comb begin
        rx_acc_d  = rx_acc_q;
        rx_perr_d = rx_perr_q;
        if (rx_sample && !rx_par_bit) begin
            rx_acc_d = (rx_first ? 1'b0 : rx_acc_q) ^ bus.rx_serial;
        end
        if (bus.rx_ready) begin
            rx_perr_d = 1'b0;
        end
        if (rx_complete) begin
            rx_perr_d = rx_par_bit && (bus.rx_serial != rx_acc_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_acc_q  <= 1'b0;
            rx_perr_q <= 1'b0;
        end else begin
            rx_acc_q  <= rx_acc_d;
            rx_perr_q <= rx_perr_d;
        end
    end

    assign bus.rx_parity_err = rx_perr_q;
`else
    assign bus.rx_parity_err = 1'b0;
`endif

endmodule
